// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words from the FIFO read side to a downstream sink.
interface fifo_rd_stream_if #(
    parameter int DSIZE = 8
);
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the async FIFO: pulls words into a small circular buffer
// and presents them on a valid/ready stream, counting accepted words.
module fifo_rd_stream #(
    parameter  int DSIZE      = 8,
    parameter  int RD_LAT     = 0,
    parameter  int OBUF_DEPTH = 4,
    parameter  int CNTW       = 16,
    localparam int OW         = $clog2(OBUF_DEPTH + 1)
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rempty,
    input  logic [DSIZE-1:0]     rdata,
    output logic                 rinc,
    input  logic                 rflush,
    fifo_rd_stream_if.master     m,
    output logic [OW-1:0]        occ,
    output logic [CNTW-1:0]      xfer_cnt
);

    localparam int             IW        = $clog2(OBUF_DEPTH);
    localparam int             OW1       = OW + 1;
    localparam logic [IW-1:0]  LAST_IDX  = IW'(OBUF_DEPTH - 1);
    localparam logic [OW-1:0]  FULL_OCC  = OW'(OBUF_DEPTH);
    localparam logic [OW:0]    DEPTH_LVL = OW1'(OBUF_DEPTH);

    logic [DSIZE-1:0] mem [OBUF_DEPTH];
    logic [IW-1:0]    head;
    logic [IW-1:0]    tail;
    logic             inflight;
    logic             push;
    logic             pop;
    logic [OW:0]      level;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // A read still in flight already owns a buffer slot, so it counts toward the level.
    assign level = {1'b0, occ} + {{OW{1'b0}}, inflight};
    assign rinc  = !rrst_n && !rempty && !rflush && (level < DEPTH_LVL);

    assign m.m_valid = (occ != '0);
    assign m.m_data  = mem[head];
    assign pop       = m.m_valid && m.m_ready;
    assign push      = (RD_LAT == 0) ? rinc : (inflight && !rflush);

    always_ff @(posedge rclk or posedge rrst_n) begin
        if (rrst_n) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            xfer_cnt <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            inflight <= (RD_LAT == 1) ? rinc : 1'b0;
            if (pop) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            // A flush drops everything buffered; a pop in the same cycle was still delivered.
            if (rflush) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                if (push) begin
                    mem[tail] <= rdata;
                    tail      <= next_idx(tail);
                end
                if (pop) begin
                    head <= next_idx(head);
                end
                if (push && !pop) begin
                    occ <= occ + 1'b1;
                end else if (pop && !push) begin
                    occ <= occ - 1'b1;
                end
            end
        end
    end

    assert property (@(posedge rclk) disable iff (rrst_n) !(push && (occ == FULL_OCC)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Drives a zero-latency and a one-cycle-latency instance side by side and compares
// both against a queue-level model of words read, in flight and delivered.
module tb_fifo_rd_stream;

    localparam int DEPTH = 4;

    logic        rclk    = 1'b0;
    logic        rrst_n  = 1'b1;
    logic        rempty  = 1'b1;
    logic        rflush  = 1'b0;
    logic        m_ready = 1'b0;
    logic [7:0]  rdata0;
    logic [7:0]  rdata1;
    logic        rinc0;
    logic        rinc1;
    logic [2:0]  occ0;
    logic [2:0]  occ1;
    logic [15:0] xfer0;
    logic [3:0]  xfer1;
    int unsigned src0 = 0;
    int unsigned src1 = 0;
    int          tests = 0;
    int          fails = 0;

    fifo_rd_stream_if #(.DSIZE(8)) s0 ();
    fifo_rd_stream_if #(.DSIZE(8)) s1 ();
    assign s0.m_ready = m_ready;
    assign s1.m_ready = m_ready;

    fifo_rd_stream #(.DSIZE(8), .RD_LAT(0), .OBUF_DEPTH(DEPTH), .CNTW(16)) dut0 (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata0), .rinc(rinc0),
        .rflush(rflush), .m(s0), .occ(occ0), .xfer_cnt(xfer0)
    );

    fifo_rd_stream #(.DSIZE(8), .RD_LAT(1), .OBUF_DEPTH(DEPTH), .CNTW(4)) dut1 (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata1), .rinc(rinc1),
        .rflush(rflush), .m(s1), .occ(occ1), .xfer_cnt(xfer1)
    );

    always #5 rclk = ~rclk;

    // FIFO memory stand-ins: word n carries value n; the registered one returns junk when idle.
    assign rdata0 = src0[7:0];
    always @(posedge rclk) begin
        if (rinc0) src0 <= src0 + 1;
        if (rinc1) begin
            rdata1 <= src1[7:0];
            src1   <= src1 + 1;
        end else begin
            rdata1 <= 8'($urandom);
        end
    end

    logic       act_rinc[2];
    logic       act_valid[2];
    logic [7:0] act_data[2];
    int         act_occ[2];
    int         act_xfer[2];
    always_comb begin
        act_rinc[0]  = rinc0;       act_rinc[1]  = rinc1;
        act_valid[0] = s0.m_valid;  act_valid[1] = s1.m_valid;
        act_data[0]  = s0.m_data;   act_data[1]  = s1.m_data;
        act_occ[0]   = int'(occ0);  act_occ[1]   = int'(occ1);
        act_xfer[0]  = int'(xfer0); act_xfer[1]  = int'(xfer1);
    end

    // Model: every read word is queued with the cycle it becomes visible (read cycle + 1 + latency).
    int         mhd[2] = '{0, 0};
    int         mtl[2] = '{0, 0};
    int         mrd[2] = '{0, 0};
    int         mxf[2] = '{0, 0};
    logic [7:0] mdat[2][256];
    int         marr[2][256];
    int         cyc = 0;

    function automatic int exp_cnt(int d);
        return mtl[d] - mhd[d];
    endfunction

    function automatic int exp_occ(int d);
        int n = 0;
        for (int i = mhd[d]; i < mtl[d]; i++) if (marr[d][i % 256] <= cyc) n++;
        return n;
    endfunction

    function automatic logic exp_valid(int d);
        return exp_occ(d) != 0;
    endfunction

    function automatic logic [7:0] exp_data(int d);
        return mdat[d][mhd[d] % 256];
    endfunction

    function automatic logic exp_rinc(int d);
        return !rrst_n && !rempty && !rflush && (exp_cnt(d) < DEPTH);
    endfunction

    function automatic int exp_xfer(int d);
        return (d == 0) ? (mxf[d] % 65536) : (mxf[d] % 16);
    endfunction

    always @(posedge rclk or posedge rrst_n) begin
        logic r;
        logic p;
        if (rrst_n) begin
            for (int d = 0; d < 2; d++) begin
                mhd[d] = mtl[d];
                mxf[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                r = exp_rinc(d);
                p = exp_valid(d) && m_ready;
                if (p) begin
                    mhd[d]++;
                    mxf[d]++;
                end
                if (rflush) mhd[d] = mtl[d];
                if (r) begin
                    mdat[d][mtl[d] % 256] = 8'(mrd[d]);
                    marr[d][mtl[d] % 256] = cyc + 1 + d;
                    mtl[d]++;
                    mrd[d]++;
                end
            end
            cyc++;
        end
    end

    task automatic test_reset();
        rrst_n = 1'b1; rempty = 1'b0; rflush = 1'b0; m_ready = 1'b1;
        repeat (3) @(negedge rclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (act_rinc[d] !== 1'b0) begin fails++; $display("[TB] FAIL reset_rinc dut%0d: got %b want 0", d, act_rinc[d]); end
            tests++;
            if (act_valid[d] !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid dut%0d: got %b want 0", d, act_valid[d]); end
            tests++;
            if (act_occ[d] != 0) begin fails++; $display("[TB] FAIL reset_occ dut%0d: got %0d want 0", d, act_occ[d]); end
            tests++;
            if (act_xfer[d] != 0) begin fails++; $display("[TB] FAIL reset_xfer dut%0d: got %0d want 0", d, act_xfer[d]); end
            tests++;
            if (act_data[d] !== 8'h00) begin fails++; $display("[TB] FAIL reset_data dut%0d: got %h want 00", d, act_data[d]); end
        end
    endtask

    task automatic test_stream();
        int first_rinc[2];
        int first_valid[2];
        first_rinc  = '{-1, -1};
        first_valid = '{-1, -1};
        @(negedge rclk);
        rrst_n = 1'b0; rempty = 1'b0; m_ready = 1'b1; rflush = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge rclk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (first_rinc[d] < 0 && act_rinc[d]) first_rinc[d] = c;
                if (first_valid[d] < 0 && act_valid[d]) first_valid[d] = c;
                tests++;
                if (act_rinc[d] !== exp_rinc(d)) begin fails++; $display("[TB] FAIL stream_rinc dut%0d c%0d: got %b want %b", d, c, act_rinc[d], exp_rinc(d)); end
                tests++;
                if (act_valid[d] !== exp_valid(d)) begin fails++; $display("[TB] FAIL stream_valid dut%0d c%0d: got %b want %b", d, c, act_valid[d], exp_valid(d)); end
                if (exp_valid(d)) begin
                    tests++;
                    if (act_data[d] !== exp_data(d)) begin fails++; $display("[TB] FAIL stream_data dut%0d c%0d: got %h want %h", d, c, act_data[d], exp_data(d)); end
                end
                tests++;
                if (act_xfer[d] != exp_xfer(d)) begin fails++; $display("[TB] FAIL stream_xfer dut%0d c%0d: got %0d want %0d", d, c, act_xfer[d], exp_xfer(d)); end
            end
        end
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (first_valid[d] - first_rinc[d] != 1 + d) begin
                fails++;
                $display("[TB] FAIL stream_latency dut%0d: got %0d cycles want %0d", d, first_valid[d] - first_rinc[d], 1 + d);
            end
        end
    endtask

    task automatic test_backpressure();
        int pulses[2];
        int n;
        pulses = '{0, 0};
        @(negedge rclk);
        rempty = 1'b1; m_ready = 1'b1;
        repeat (2) @(negedge rclk);
        n = 0;
        while ((s0.m_valid || s1.m_valid) && n < 20) begin @(negedge rclk); n++; end
        tests++;
        if (s0.m_valid || s1.m_valid) begin fails++; $display("[TB] FAIL bp_drain: valid got %b%b want 00", s0.m_valid, s1.m_valid); end
        rempty = 1'b0; m_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge rclk);
            #1;
            for (int d = 0; d < 2; d++) begin
                pulses[d] += int'(act_rinc[d]);
                tests++;
                if (act_rinc[d] !== exp_rinc(d)) begin fails++; $display("[TB] FAIL bp_rinc dut%0d c%0d: got %b want %b", d, c, act_rinc[d], exp_rinc(d)); end
                if (c >= 3) begin
                    tests++;
                    if (act_data[d] !== exp_data(d)) begin fails++; $display("[TB] FAIL bp_hold dut%0d c%0d: got %h want %h", d, c, act_data[d], exp_data(d)); end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (pulses[d] != DEPTH) begin fails++; $display("[TB] FAIL bp_pulses dut%0d: got %0d want %0d", d, pulses[d], DEPTH); end
            tests++;
            if (act_occ[d] != DEPTH) begin fails++; $display("[TB] FAIL bp_occ dut%0d: got %0d want %0d", d, act_occ[d], DEPTH); end
        end
        @(negedge rclk);
        m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge rclk);
            #1;
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (act_valid[d] !== exp_valid(d)) begin fails++; $display("[TB] FAIL bp_release_valid dut%0d c%0d: got %b want %b", d, c, act_valid[d], exp_valid(d)); end
                if (exp_valid(d)) begin
                    tests++;
                    if (act_data[d] !== exp_data(d)) begin fails++; $display("[TB] FAIL bp_release_data dut%0d c%0d: got %h want %h", d, c, act_data[d], exp_data(d)); end
                end
            end
        end
    endtask

    task automatic test_rempty_toggle();
        for (int c = 0; c < 120; c++) begin
            @(negedge rclk);
            rempty  = ((c / 3) % 2) == 1;
            m_ready = 1'($urandom_range(0, 1));
            #1;
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (rempty && act_rinc[d]) begin fails++; $display("[TB] FAIL toggle_rinc_empty dut%0d c%0d: got %b want 0", d, c, act_rinc[d]); end
                tests++;
                if (act_rinc[d] !== exp_rinc(d)) begin fails++; $display("[TB] FAIL toggle_rinc dut%0d c%0d: got %b want %b", d, c, act_rinc[d], exp_rinc(d)); end
                tests++;
                if (act_occ[d] != exp_occ(d)) begin fails++; $display("[TB] FAIL toggle_occ dut%0d c%0d: got %0d want %0d", d, c, act_occ[d], exp_occ(d)); end
                if (exp_valid(d) && m_ready) begin
                    tests++;
                    if (act_data[d] !== exp_data(d)) begin fails++; $display("[TB] FAIL toggle_order dut%0d c%0d: got %h want %h", d, c, act_data[d], exp_data(d)); end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (act_xfer[d] != exp_xfer(d)) begin fails++; $display("[TB] FAIL toggle_xfer dut%0d: got %0d want %0d", d, act_xfer[d], exp_xfer(d)); end
        end
    endtask

    task automatic test_flush();
        logic [7:0] want[2];
        logic       got[2];
        int         n;
        logic       found;
        got = '{1'b0, 1'b0};
        @(negedge rclk);
        rempty = 1'b1; m_ready = 1'b1; rflush = 1'b0;
        repeat (2) @(negedge rclk);
        n = 0;
        while ((s0.m_valid || s1.m_valid) && n < 20) begin @(negedge rclk); n++; end
        rempty = 1'b0; m_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (c > 0) @(negedge rclk);
            #1;
            if (exp_occ(1) == 3 && exp_cnt(1) == 4) found = 1'b1;
        end
        tests++;
        if (!found) begin fails++; $display("[TB] FAIL flush_setup: occ3+inflight not reached, occ got %0d want 3", act_occ[1]); end
        tests++;
        if (act_occ[1] != 3) begin fails++; $display("[TB] FAIL flush_pre_occ dut1: got %0d want 3", act_occ[1]); end
        rflush = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (act_rinc[d] !== 1'b0) begin fails++; $display("[TB] FAIL flush_rinc dut%0d: got %b want 0", d, act_rinc[d]); end
        end
        @(negedge rclk);
        rflush = 1'b0; m_ready = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            want[d] = 8'(mrd[d]);
            tests++;
            if (act_valid[d] !== 1'b0) begin fails++; $display("[TB] FAIL flush_valid dut%0d: got %b want 0", d, act_valid[d]); end
            tests++;
            if (act_occ[d] != 0) begin fails++; $display("[TB] FAIL flush_occ dut%0d: got %0d want 0", d, act_occ[d]); end
            tests++;
            if (act_xfer[d] != exp_xfer(d)) begin fails++; $display("[TB] FAIL flush_xfer dut%0d: got %0d want %0d", d, act_xfer[d], exp_xfer(d)); end
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge rclk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (!got[d] && act_valid[d]) begin
                    got[d] = 1'b1;
                    tests++;
                    if (act_data[d] !== want[d]) begin fails++; $display("[TB] FAIL flush_next_word dut%0d: got %h want %h", d, act_data[d], want[d]); end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (!got[d]) begin fails++; $display("[TB] FAIL flush_resume dut%0d: valid got 0 want 1 within 6 cycles", d); end
        end
    endtask

    task automatic test_wrap();
        int   n;
        int   prev;
        logic seen_wrap;
        @(negedge rclk);
        rrst_n = 1'b1; rempty = 1'b0; m_ready = 1'b1; rflush = 1'b0;
        @(negedge rclk);
        rrst_n = 1'b0;
        seen_wrap = 1'b0;
        prev = 0;
        n = 0;
        while (mxf[1] < 17 && n < 60) begin
            @(negedge rclk);
            #1;
            n++;
            tests++;
            if (act_xfer[1] != exp_xfer(1)) begin fails++; $display("[TB] FAIL wrap_seq: got %0d want %0d", act_xfer[1], exp_xfer(1)); end
            if (prev == 15 && act_xfer[1] == 0) seen_wrap = 1'b1;
            prev = act_xfer[1];
        end
        m_ready = 1'b0;
        @(negedge rclk);
        #1;
        tests++;
        if (act_xfer[1] != 1) begin fails++; $display("[TB] FAIL wrap_final: got %0d want 1", act_xfer[1]); end
        tests++;
        if (!seen_wrap) begin fails++; $display("[TB] FAIL wrap_seen: 15->0 step got 0 want 1"); end
        tests++;
        if (act_xfer[0] != exp_xfer(0)) begin fails++; $display("[TB] FAIL wrap_xfer_wide: got %0d want %0d", act_xfer[0], exp_xfer(0)); end
    endtask

    task automatic test_reset_midstream();
        int n;
        @(negedge rclk);
        rempty = 1'b1; m_ready = 1'b1; rflush = 1'b0;
        repeat (8) @(negedge rclk);
        rempty = 1'b0; m_ready = 1'b0;
        n = 0;
        #1;
        while (act_occ[0] != 2 && n < 10) begin @(negedge rclk); #1; n++; end
        tests++;
        if (act_occ[0] != 2) begin fails++; $display("[TB] FAIL rstmid_setup: occ got %0d want 2", act_occ[0]); end
        #2;
        rrst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (act_valid[d] !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_valid dut%0d: got %b want 0", d, act_valid[d]); end
            tests++;
            if (act_rinc[d] !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_rinc dut%0d: got %b want 0", d, act_rinc[d]); end
            tests++;
            if (act_occ[d] != 0) begin fails++; $display("[TB] FAIL rstmid_occ dut%0d: got %0d want 0", d, act_occ[d]); end
        end
        @(negedge rclk);
        rrst_n = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge rclk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (c == 0) begin
                    tests++;
                    if (act_xfer[d] != 0) begin fails++; $display("[TB] FAIL rstmid_cnt_restart dut%0d: got %0d want 0", d, act_xfer[d]); end
                end
                tests++;
                if (act_xfer[d] != exp_xfer(d)) begin fails++; $display("[TB] FAIL rstmid_xfer dut%0d c%0d: got %0d want %0d", d, c, act_xfer[d], exp_xfer(d)); end
                if (exp_valid(d)) begin
                    tests++;
                    if (act_data[d] !== exp_data(d)) begin fails++; $display("[TB] FAIL rstmid_data dut%0d c%0d: got %h want %h", d, c, act_data[d], exp_data(d)); end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time got 200000 want less");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_rempty_toggle();
        test_flush();
        test_wrap();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
